// File: rtl/ifmap_row_feeder_if.sv
// Pixel-in / tagged-word-out stream bundle of the IFMap row feeder.
interface ifmap_row_feeder_if #(
    parameter int IFMAP_WIDTH = 18
);
    logic                   pix_valid;
    logic [IFMAP_WIDTH-3:0] pix_data;
    logic                   pix_ready;
    logic                   ifmap_ready;
    logic                   ifmap_wen;
    logic [IFMAP_WIDTH-1:0] ifmap_dout;

    modport master (
        input  pix_valid, pix_data, ifmap_ready,
        output pix_ready, ifmap_wen, ifmap_dout
    );

    modport slave (
        output pix_valid, pix_data, ifmap_ready,
        input  pix_ready, ifmap_wen, ifmap_dout
    );
endinterface

// File: rtl/ifmap_row_feeder.sv
// Tags raw pixels with start/end-of-row flags and frames num_rows x row_len per start.
// Latency: pixel accepted in cycle N is written to the IFMap FIFO in cycle N+1 at the earliest.
// Backpressure: ifmap_ready low holds the output word and drops pix_ready; nothing is lost or repeated.
module ifmap_row_feeder #(
    parameter int IFMAP_WIDTH  = 18,
    parameter int ROW_LEN_SIZE = 8,
    parameter int ROW_CNT_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ROW_LEN_SIZE-1:0] row_len,
    input  logic [ROW_CNT_SIZE-1:0] num_rows,
    ifmap_row_feeder_if.master      bus,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ROW_LEN_SIZE-1:0] row_len_q;
    logic [ROW_CNT_SIZE-1:0] num_rows_q;
    logic [ROW_LEN_SIZE-1:0] col_cnt;
    logic [ROW_CNT_SIZE-1:0] row_cnt;
    logic                    out_vld;
    logic [IFMAP_WIDTH-1:0]  out_word;

    logic [ROW_LEN_SIZE-1:0] last_col;
    logic [ROW_CNT_SIZE-1:0] last_row;
    logic                    pix_ready;
    logic                    ifmap_wen;
    logic                    accept;
    logic                    col_end;
    logic                    frame_end;

    assign last_col  = row_len_q - ROW_LEN_SIZE'(1);
    assign last_row  = num_rows_q - ROW_CNT_SIZE'(1);
    assign col_end   = (col_cnt == last_col);
    assign frame_end = col_end && (row_cnt == last_row);

    // The single output register may refill in the same cycle it drains.
    assign pix_ready = (state == STREAM) && (!out_vld || bus.ifmap_ready);
    assign ifmap_wen = out_vld && bus.ifmap_ready;
    assign accept    = bus.pix_valid && pix_ready;

    assign bus.pix_ready  = pix_ready;
    assign bus.ifmap_wen  = ifmap_wen;
    assign bus.ifmap_dout = out_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_len_q  <= '0;
            num_rows_q <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            out_vld    <= 1'b0;
            out_word   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_len_q  <= row_len;
                        num_rows_q <= num_rows;
                        col_cnt    <= '0;
                        row_cnt    <= '0;
                        // An empty frame skips straight to the done pulse.
                        if (row_len == '0 || num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                            busy  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept && frame_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_vld || ifmap_wen) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                out_word <= {(col_cnt == '0), col_end, bus.pix_data};
                out_vld  <= 1'b1;
                if (col_end) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + ROW_CNT_SIZE'(1);
                end else begin
                    col_cnt <= col_cnt + ROW_LEN_SIZE'(1);
                end
            end else if (ifmap_wen) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Scoreboarded bench for ifmap_row_feeder: directed cases plus randomized frames.
module tb_ifmap_row_feeder;
    localparam int W = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       busy;
    logic       done;

    ifmap_row_feeder_if #(.IFMAP_WIDTH(W)) bus ();

    ifmap_row_feeder #(
        .IFMAP_WIDTH (W),
        .ROW_LEN_SIZE(8),
        .ROW_CNT_SIZE(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .row_len (row_len),
        .num_rows(num_rows),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.ifmap_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                failures++;
                $display("FAIL unexpected_write: got %h expected no write", bus.ifmap_dout);
            end else begin
                check("word", bus.ifmap_dout, exp_q.pop_front());
            end
        end
    end

    // kind: 0 plain, 1 three-cycle stall after 2nd word, 2 reset after 3rd accept, 3 restart pulse mid-frame
    task automatic run_frame(input int len, input int rows, input int bubble_pct,
                             input int stall_pct, input int kind, input int base);
        int n;
        int sent;
        int done_cyc;
        logic [W-3:0] data[];
        n        = len * rows;
        sent     = 0;
        done_cyc = -1;
        data     = new[n > 0 ? n : 1];
        for (int i = 0; i < n; i++) begin
            data[i] = (base >= 0) ? (W-2)'(base + i) : (W-2)'($urandom);
            exp_q.push_back({(i % len) == 0, (i % len) == len - 1, data[i]});
        end

        @(posedge clk); #1;
        row_len  = 8'(len);
        num_rows = 8'(rows);
        start    = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.ifmap_ready = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        row_len  = 8'd0;
        num_rows = 8'd0;

        for (int cyc = 1; cyc <= 2000; cyc++) begin
            bus.pix_valid   = (sent < n) && ($urandom_range(99) >= bubble_pct);
            bus.pix_data    = data[sent < n ? sent : 0];
            bus.ifmap_ready = ($urandom_range(99) >= stall_pct);
            if (kind == 1) bus.ifmap_ready = !(cyc >= 4 && cyc <= 6);
            if (kind == 3) begin
                start   = (cyc == 3);
                row_len = (cyc == 3) ? 8'd9 : 8'd0;
            end
            @(negedge clk);
            if (cyc == 1 && n > 0) check("busy_in_stream", W'(busy), W'(1));
            if (kind == 1 && cyc >= 4 && cyc <= 6) begin
                check("stall_pix_ready", W'(bus.pix_ready), W'(0));
                check("stall_held_word", bus.ifmap_dout, W'(3));
            end
            if (bus.pix_valid && bus.pix_ready) sent++;
            if (kind == 2 && sent == 3) begin
                @(posedge clk); #1;
                rst = 1'b1;
                bus.pix_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("rst_pix_ready", W'(bus.pix_ready), W'(0));
                check("rst_wen", W'(bus.ifmap_wen), W'(0));
                check("rst_dout", bus.ifmap_dout, W'(0));
                check("rst_busy_done", W'({busy, done}), W'(0));
                return;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        if (done_cyc < 0) begin
            tests_run++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end else begin
            if (n == 0) check("empty_done_cycle", W'(done_cyc), W'(1));
            else if (kind == 1) check("stall_done_cycle", W'(done_cyc), W'(n + 5));
            else if (bubble_pct == 0 && stall_pct == 0) check("done_cycle", W'(done_cyc), W'(n + 2));
            check("busy_at_done", W'(busy), W'(0));
            @(negedge clk);
            check("done_one_cycle", W'(done), W'(0));
            check("all_words_written", W'(exp_q.size()), W'(0));
            exp_q.delete();
        end
        bus.pix_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        row_len         = 8'd0;
        num_rows        = 8'd0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.ifmap_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pix_ready", W'(bus.pix_ready), W'(0));
        check("reset_wen", W'(bus.ifmap_wen), W'(0));
        check("reset_dout", bus.ifmap_dout, W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(4, 2, 0, 0, 0, 1);
        run_frame(1, 3, 0, 0, 0, 10);
        run_frame(4, 2, 0, 0, 1, 1);
        run_frame(0, 3, 0, 0, 0, 1);
        run_frame(5, 0, 0, 0, 0, 1);
        run_frame(4, 2, 0, 0, 2, 1);
        run_frame(2, 1, 0, 0, 0, 20);
        run_frame(4, 2, 0, 0, 3, 1);

        for (int k = 0; k < 10; k++) begin
            run_frame($urandom_range(6), $urandom_range(4, 1),
                      $urandom_range(50), $urandom_range(50), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
